dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port synchronous data memory (S-bit words, L locations, combinational read, write on posedge clk). Port 0 is the CPU MEM-stage load/store path. Port 1 is the debug/loader path. The block picks one request per cycle with round-robin priority, drives the memory's address, write-data, read and write strobes, and returns registered read data to the winning port one cycle later.

## Interface
- S, 32, data word width
- L, 256, memory depth; AW = $clog2(L) address bits
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- p0_req, p1_req  in  1  request valid
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  AW  word address
- p0_wdata, p1_wdata  in  S  write data
- p0_ready, p1_ready  out  1  grant/accept, combinational, same cycle as req
- p0_rvalid, p1_rvalid  out  1  read data valid, registered
- p0_rdata, p1_rdata  out  S  read data, registered
- mem_a  out  AW  to memory address
- mem_din  out  S  to memory write data
- mem_mread, mem_mwrite  out  1  to memory strobes
- mem_dout  in  S  from memory, combinational read data
- p0_lock, p1_lock  in  1  hold-ownership request; present only with DMEM_ARB_LOCK_EN

## Operation
- Handshake: a transaction is accepted in the cycle where pX_req=1 and pX_ready=1. A requester holds req, we, addr and wdata stable until it is accepted.
- Arbitration:
  - Only one port requests: that port is granted.
  - Both ports request: the port named by the 1-bit priority pointer `prio` is granted.
  - After any grant, `prio` points to the other port.
  - `prio` does not change in a cycle with no grant.
- Memory drive during a granted cycle:
  - mem_a = winner addr.
  - mem_din = winner wdata.
  - mem_mwrite = winner we.
  - mem_mread = ~winner we.
- No grant: mem_mread=0, mem_mwrite=0, mem_a=0, mem_din=0.
- Read accepted: mem_dout is captured into the winner's rdata at the next posedge, and that port's rvalid=1 for exactly one cycle.
- Write accepted: no rvalid. The write lands in memory at the posedge ending the grant cycle.
- rdata holds its last value when rvalid=0. The non-winning port's rdata is unchanged.
- Back-to-back grants to the same port are legal when the other port is idle (one transaction per cycle).
- FSM (lock builds only): states IDLE, LOCK0, LOCK1.

## Timing
- Reset values (rst=1 at posedge):
  - prio=0 (port 0 first).
  - State IDLE.
  - p0_rvalid=p1_rvalid=0.
  - p0_rdata=p1_rdata=0.
- ready and mem_* outputs are combinational from req/state/prio. They read 0 while no request is pending.
- Read latency: accept in cycle N, rdata/rvalid valid in cycle N+1.
- Read-after-write to the same address:
  - Write accepted in cycle N.
  - Read accepted in cycle N+1 returns the new data in cycle N+2.
- Reset mid-transaction: rst asserted in cycle N.
  - Any rvalid that would appear in N+1 is suppressed.
  - Lock is dropped.
  - A write granted in the same cycle as rst is still presented to memory; the memory itself has no reset.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - pX_lock ports exist.
  - A grant to port X with pX_lock=1 moves the FSM to LOCKX.
  - In LOCKX only port X can be granted. The other port's ready=0 regardless of prio.
  - LOCKX returns to IDLE in any cycle where pX_lock=0, and normal arbitration applies in that same cycle.
  - A port issues a locked read then a write in the next cycle for an atomic read-modify-write.
  - prio still toggles after each grant.
- DMEM_ARB_LOCK_EN undefined:
  - No lock ports and no FSM state.
  - Pure round-robin as above.

## Test plan
- Reset, then p0 read addr 0x10 (memory preloaded 0x10 → 0xDEADBEEF): p0_ready=1 in cycle 1, p0_rvalid=1 with p0_rdata=0xDEADBEEF in cycle 2, p1_rvalid stays 0.
- Both ports request reads every cycle for 4 cycles right after reset: grants alternate p0,p1,p0,p1; mem_mread=1 each cycle; each rvalid pulses one cycle after its grant.
- p1 write addr 0x20 data 0x12345678, then p0 read 0x20 the next cycle: mem_mwrite=1 only in the write cycle; p0_rdata=0x12345678.
- Idle cycles with no requests: mem_mread=mem_mwrite=0, prio unchanged; next simultaneous request goes to the port prio held before the idle period.
- rst asserted the cycle a p0 read is granted: p0_rvalid=0 in the following cycle, prio=0, state IDLE.
- (DMEM_ARB_LOCK_EN) p0 locked read 0x30, p0 write 0x30 with lock still high, p1 requesting throughout: p1_ready=0 for both cycles; p0 drops lock in the third cycle, and p1 is granted in that cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Lock wires exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
  parameter int S  = 32,
  parameter int AW = 8
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [S-1:0]  p0_wdata;
  logic          p0_ready;
  logic          p0_rvalid;
  logic [S-1:0]  p0_rdata;
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [S-1:0]  p1_wdata;
  logic          p1_ready;
  logic          p1_rvalid;
  logic [S-1:0]  p1_rdata;
  logic [AW-1:0] mem_a;
  logic [S-1:0]  mem_din;
  logic          mem_mread;
  logic          mem_mwrite;
  logic [S-1:0]  mem_dout;
`ifdef DMEM_ARB_LOCK_EN
  logic          p0_lock;
  logic          p1_lock;
`endif

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    output mem_a, mem_din, mem_mread, mem_mwrite,
    input  mem_dout
`ifdef DMEM_ARB_LOCK_EN
    , input p0_lock, p1_lock
`endif
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  mem_a, mem_din, mem_mread, mem_mwrite,
    output mem_dout
`ifdef DMEM_ARB_LOCK_EN
    , output p0_lock, p1_lock
`endif
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the single-port data memory.
// Define DMEM_ARB_LOCK_EN to add the lock FSM for atomic read-modify-write.
module dmem_arbiter #(
  parameter int S = 32,
  parameter int L = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  dmem_arbiter_if.slave bus
);
  localparam int AW = $clog2(L);

  logic          r_prio;
  logic          w_g0;
  logic          w_g1;
  logic [AW-1:0] w_a;
  logic [S-1:0]  w_din;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_own0;
  logic   w_own1;

  assign w_own0 = (r_state == LOCK0) && bus.p0_lock;
  assign w_own1 = (r_state == LOCK1) && bus.p1_lock;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A released lock falls through to normal arbitration in the same cycle
  always_comb begin
    w_g0        = 1'b0;
    w_g1        = 1'b0;
    w_state_nxt = IDLE;
    unique case (1'b1)
      w_own0: begin
        w_g0        = bus.p0_req;
        w_state_nxt = LOCK0;
      end
      w_own1: begin
        w_g1        = bus.p1_req;
        w_state_nxt = LOCK1;
      end
      default: begin
        w_g0 = bus.p0_req & (~bus.p1_req | ~r_prio);
        w_g1 = bus.p1_req & ~w_g0;
        if (w_g0 && bus.p0_lock)      w_state_nxt = LOCK0;
        else if (w_g1 && bus.p1_lock) w_state_nxt = LOCK1;
      end
    endcase
  end
`else
  always_comb begin
    w_g0 = bus.p0_req & (~bus.p1_req | ~r_prio);
    w_g1 = bus.p1_req & ~w_g0;
  end
`endif

  assign w_a   = w_g0 ? bus.p0_addr  : (w_g1 ? bus.p1_addr  : '0);
  assign w_din = w_g0 ? bus.p0_wdata : (w_g1 ? bus.p1_wdata : '0);

  assign bus.p0_ready   = w_g0;
  assign bus.p1_ready   = w_g1;
  assign bus.mem_a      = w_a;
  assign bus.mem_din    = w_din;
  assign bus.mem_mwrite = (w_g0 & bus.p0_we) | (w_g1 & bus.p1_we);
  assign bus.mem_mread  = (w_g0 & ~bus.p0_we) | (w_g1 & ~bus.p1_we);

  logic         r_rv0;
  logic         r_rv1;
  logic [S-1:0] r_rd0;
  logic [S-1:0] r_rd1;

  // r_prio=1 means port 1 wins the next tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= 1'b0;
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_rd0  <= '0;
      r_rd1  <= '0;
    end else begin
      if (w_g0 | w_g1) r_prio <= w_g0;
      r_rv0 <= w_g0 & ~bus.p0_we;
      r_rv1 <= w_g1 & ~bus.p1_we;
      if (w_g0 & ~bus.p0_we) r_rd0 <= bus.mem_dout;
      if (w_g1 & ~bus.p1_we) r_rd1 <= bus.mem_dout;
    end
  end

  assign bus.p0_rvalid = r_rv0;
  assign bus.p1_rvalid = r_rv1;
  assign bus.p0_rdata  = r_rd0;
  assign bus.p1_rdata  = r_rd1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/lock sequences,
// then random traffic checked against a queue-free transaction model.
module tb_dmem_arbiter;
  logic clk;
  logic rst;
  logic load;
  int   n_cmp;
  int   n_err;

  dmem_arbiter_if #(.S(32), .AW(8)) bus ();

  dmem_arbiter #(.S(32), .L(256)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  function automatic logic [31:0] pre(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hA5000000 | 32'(i);
  endfunction

  assign bus.mem_dout = mem[bus.mem_a];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= pre(i);
    end else if (bus.mem_mwrite) begin
      mem[bus.mem_a] <= bus.mem_din;
    end
  end

  typedef struct {
    logic        q0, we0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        q1, we1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic        e_r0, e_r1, e_rd, e_wr;
    logic [7:0]  e_a;
    logic [31:0] e_din;
    logic        e_v0, e_v1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic q0, we0, input logic [7:0] a0, input logic [31:0] d0,
    input logic q1, we1, input logic [7:0] a1, input logic [31:0] d1,
    input logic r0, r1, rd, wr, input logic [7:0] a,
    input logic [31:0] din, input logic v0, v1,
    input logic [31:0] rd0, rd1);
    vec_t v;
    v.q0 = q0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.e_r0 = r0; v.e_r1 = r1; v.e_rd = rd; v.e_wr = wr;
    v.e_a = a; v.e_din = din; v.e_v0 = v0; v.e_v1 = v1;
    v.e_rd0 = rd0; v.e_rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic q0, we0, input logic [7:0] a0, input logic [31:0] d0,
    input logic q1, we1, input logic [7:0] a1, input logic [31:0] d1);
    bus.p0_req = q0; bus.p0_we = we0;
    bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = q1; bus.p1_we = we1;
    bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  function automatic logic [79:0] act_comb();
    return 80'({bus.p0_ready, bus.p1_ready, bus.mem_mread,
                bus.mem_mwrite, bus.mem_a, bus.mem_din});
  endfunction

  function automatic logic [79:0] act_reg();
    return 80'({bus.p0_rvalid, bus.p1_rvalid,
                bus.p0_rdata, bus.p1_rdata});
  endfunction

  vec_t tbl [12];

  logic        m_prio, m_v0, m_v1, g0, g1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] smem [256];
  logic        q0r, q0w, q1r, q1w;
  logic [7:0]  q0a, q1a, ea;
  logic [31:0] q0d, q1d, ed;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    load  = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
    bus.p0_lock = 1'b0;
    bus.p1_lock = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1,0,8'h10,0, 0,0,0,0, 1,0,1,0,8'h10,0,
                 0,0,0,0);
    tbl[1]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,
                 1,0,32'hDEADBEEF,0);
    tbl[2]  = mk(1,0,8'h01,0, 1,0,8'h02,0, 0,1,1,0,8'h02,0,
                 0,0,32'hDEADBEEF,0);
    tbl[3]  = mk(1,0,8'h01,0, 1,0,8'h03,0, 1,0,1,0,8'h01,0,
                 0,1,32'hDEADBEEF,32'hA5000002);
    tbl[4]  = mk(1,0,8'h04,0, 1,0,8'h03,0, 0,1,1,0,8'h03,0,
                 1,0,32'hA5000001,32'hA5000002);
    tbl[5]  = mk(1,0,8'h04,0, 0,0,0,0, 1,0,1,0,8'h04,0,
                 0,1,32'hA5000001,32'hA5000003);
    tbl[6]  = mk(0,0,0,0, 1,1,8'h20,32'h12345678,
                 0,1,0,1,8'h20,32'h12345678,
                 1,0,32'hA5000004,32'hA5000003);
    tbl[7]  = mk(1,0,8'h20,0, 0,0,0,0, 1,0,1,0,8'h20,0,
                 0,0,32'hA5000004,32'hA5000003);
    tbl[8]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,
                 1,0,32'h12345678,32'hA5000003);
    tbl[9]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,
                 0,0,32'h12345678,32'hA5000003);
    tbl[10] = mk(1,0,8'h06,0, 1,0,8'h07,0, 0,1,1,0,8'h07,0,
                 0,0,32'h12345678,32'hA5000003);
    tbl[11] = mk(1,0,8'h06,0, 0,0,0,0, 1,0,1,0,8'h06,0,
                 0,1,32'h12345678,32'hA5000007);

    repeat (2) @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].q0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
            tbl[i].q1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("row%0d comb", i), act_comb(),
          80'({tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_rd, tbl[i].e_wr,
               tbl[i].e_a, tbl[i].e_din}));
      chk($sformatf("row%0d reg", i), act_reg(),
          80'({tbl[i].e_v0, tbl[i].e_v1, tbl[i].e_rd0, tbl[i].e_rd1}));
    end

    // Reset lands on the cycle a p0 read is granted
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 8'h05, 0, 0, 0, 0, 0);
    #1;
    chk("rst grant", 80'({bus.p0_ready, bus.mem_mread}), 80'(2'b11));
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 8'h06, 0, 1, 0, 8'h07, 0);
    #1;
    chk("rst regs", act_reg(), 80'(0));
    chk("rst prio", 80'({bus.p0_ready, bus.p1_ready}), 80'(2'b10));
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 8'h07, 0);
    #1;
    chk("rst after", 80'({bus.p0_rvalid, bus.p0_rdata}),
        80'({1'b1, 32'hA5000006}));

`ifdef DMEM_ARB_LOCK_EN
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.p0_lock = 1'b1;
    drive(1, 0, 8'h30, 0, 1, 0, 8'h31, 0);
    #1;
    chk("lock rd", act_comb(),
        80'({4'b1010, 8'h30, 32'h0}));
    @(negedge clk);
    drive(1, 1, 8'h30, 32'hCAFEF00D, 1, 0, 8'h31, 0);
    #1;
    chk("lock wr", act_comb(),
        80'({4'b1001, 8'h30, 32'hCAFEF00D}));
    chk("lock rv", 80'({bus.p0_rvalid, bus.p0_rdata}),
        80'({1'b1, 32'hA5000030}));
    @(negedge clk);
    bus.p0_lock = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 8'h31, 0);
    #1;
    chk("lock rel", act_comb(),
        80'({4'b0110, 8'h31, 32'h0}));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lock p1 rv", 80'({bus.p1_rvalid, bus.p1_rdata}),
        80'({1'b1, 32'hA5000031}));
`endif

    // Random traffic: reset first so the model starts from a known state
    for (int i = 0; i < 256; i++) smem[i] = pre(i);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_prio = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0;
    m_rd0 = '0; m_rd1 = '0;
    q0r = 1'b0; q1r = 1'b0;
    q0w = 1'b0; q1w = 1'b0;
    q0a = '0; q1a = '0; q0d = '0; q1d = '0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      drive(q0r, q0w, q0a, q0d, q1r, q1w, q1a, q1d);
      #1;
      g0 = q0r && (!q1r || !m_prio);
      g1 = q1r && !g0;
      ea = g0 ? q0a : (g1 ? q1a : 8'h00);
      ed = g0 ? q0d : (g1 ? q1d : 32'h0);
      chk("rnd comb", act_comb(),
          80'({g0, g1, (g0 && !q0w) || (g1 && !q1w),
               (g0 && q0w) || (g1 && q1w), ea, ed}));
      chk("rnd reg", act_reg(), 80'({m_v0, m_v1, m_rd0, m_rd1}));
      @(posedge clk);
      if (rst) begin
        m_prio = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0;
        m_rd0 = '0; m_rd1 = '0;
      end else begin
        if (g0 || g1) m_prio = g0;
        m_v0 = g0 && !q0w;
        m_v1 = g1 && !q1w;
        if (m_v0) m_rd0 = smem[q0a];
        if (m_v1) m_rd1 = smem[q1a];
      end
      if ((g0 && q0w) || (g1 && q1w)) smem[ea] = ed;
      if (g0 || !q0r) begin
        q0r = ($urandom_range(0, 2) != 0);
        q0w = $urandom_range(0, 1) == 1;
        q0a = 8'h40 | 8'($urandom_range(0, 15));
        q0d = $urandom;
      end
      if (g1 || !q1r) begin
        q1r = ($urandom_range(0, 2) != 0);
        q1w = $urandom_range(0, 1) == 1;
        q1a = 8'h40 | 8'($urandom_range(0, 15));
        q1d = $urandom;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
